// File: rtl/hvac_pkg.sv
// Shared types and default thresholds for the HVAC zone scheduler.
package hvac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DEAD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } mode_e;

  localparam int LOW_TH_DEF  = 18;
  localparam int TARGET_DEF  = 20;
  localparam int HIGH_TH_DEF = 22;

endpackage

// File: rtl/zone_rr_picker.sv
// Combinational round-robin pick: first requesting zone at or above ptr, wrapping.
module zone_rr_picker #(
  parameter int NUM_ZONES = 4,
  parameter int IDX_W     = $clog2(NUM_ZONES)
) (
  input  logic [NUM_ZONES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     pick
);

  logic [2*NUM_ZONES-1:0] req_dbl;
  logic [NUM_ZONES-1:0]   rot;
  logic [IDX_W-1:0]       offset;
  logic [IDX_W:0]         sum;

  // Rotating a doubled vector puts zone ptr at bit 0, so the lowest set bit is the winner.
  assign req_dbl = {req, req} >> ptr;
  assign rot     = req_dbl[NUM_ZONES-1:0];

  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int j = NUM_ZONES - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid  = 1'b1;
        offset = IDX_W'(j);
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IDX_W+1)'(NUM_ZONES)) sum = sum - (IDX_W+1)'(NUM_ZONES);
    pick = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Time-shares one heat/cool plant across zones: hysteresis demand, round-robin grant,
// min/max on-time and a fixed all-off dead time between grants. All outputs registered.
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int NUM_ZONES   = 4,
  parameter int TEMP_W      = 5,
  parameter int LOW_TH      = LOW_TH_DEF,
  parameter int HIGH_TH     = HIGH_TH_DEF,
  parameter int TARGET      = TARGET_DEF,
  parameter int MIN_ON      = 8,
  parameter int MAX_ON      = 32,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_ZONES*TEMP_W-1:0]  temp_flat,
  output logic [NUM_ZONES-1:0]         zone_sel,
  output logic                         heating,
  output logic                         cooling,
  output logic [$clog2(NUM_ZONES)-1:0] active_zone,
  output logic                         busy
);

  localparam int IDX_W   = $clog2(NUM_ZONES);
  localparam int CNT_MAX = (MAX_ON > DEAD_CYCLES) ? MAX_ON : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_ZONES-1:0] sel_d;
  logic                 heat_d, cool_d, busy_d;
  logic [IDX_W-1:0]     act_d;

  logic [TEMP_W-1:0]    temps [NUM_ZONES];
  logic [NUM_ZONES-1:0] heat_req, cool_req, req;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick;
  logic                 satisfied, other_req, exit_serve;

  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++) begin
      temps[i]    = temp_flat[i*TEMP_W +: TEMP_W];
      heat_req[i] = temps[i] <= TEMP_W'(LOW_TH);
      cool_req[i] = temps[i] >= TEMP_W'(HIGH_TH);
    end
  end

  assign req = heat_req | cool_req;

  zone_rr_picker #(
    .NUM_ZONES (NUM_ZONES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  // Satisfaction follows the mode latched at grant, not the zone's current request.
  assign satisfied = (mode_q == HEAT) ? (temps[active_zone] >= TEMP_W'(TARGET))
                                      : (temps[active_zone] <= TEMP_W'(TARGET));
  assign other_req  = |(req & ~zone_sel);
  assign exit_serve = !enable
                   || (satisfied && cnt_q >= CNT_W'(MIN_ON - 1))
                   || (other_req && cnt_q >= CNT_W'(MAX_ON - 1));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    sel_d    = zone_sel;
    heat_d   = heating;
    cool_d   = cooling;
    act_d    = active_zone;
    busy_d   = busy;
    case (state_q)
      IDLE: begin
        if (enable && pick_valid) begin
          state_d = SERVE;
          sel_d   = {{(NUM_ZONES-1){1'b0}}, 1'b1} << pick;
          act_d   = pick;
          heat_d  = heat_req[pick];
          cool_d  = cool_req[pick];
          mode_d  = heat_req[pick] ? HEAT : COOL;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SERVE: begin
        if (exit_serve) begin
          state_d  = DEAD;
          mode_d   = OFF;
          sel_d    = '0;
          heat_d   = 1'b0;
          cool_d   = 1'b0;
          cnt_d    = '0;
          rr_ptr_d = (active_zone == IDX_W'(NUM_ZONES - 1)) ? '0 : active_zone + 1'b1;
        end else if (cnt_q < CNT_W'(MAX_ON)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEAD: begin
        if (cnt_q >= CNT_W'(DEAD_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        mode_d  = OFF;
        sel_d   = '0;
        heat_d  = 1'b0;
        cool_d  = 1'b0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= OFF;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      zone_sel    <= '0;
      heating     <= 1'b0;
      cooling     <= 1'b0;
      active_zone <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      zone_sel    <= sel_d;
      heating     <= heat_d;
      cooling     <= cool_d;
      active_zone <= act_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: doc/hvac_zone_scheduler.md
Name: hvac_zone_scheduler

Overview:
- Time-shares one heating/cooling plant between NUM_ZONES zones, each with its own 5-bit temperature sensor.
- Detects per-zone heat/cool demand using hysteresis thresholds.
- Grants the plant to one zone at a time, round-robin, and drives the damper select plus the heating/cooling outputs.
- Enforces minimum on-time, maximum on-time under contention, and a dead-time between grants, which protects the plant.
- Sits between the sensor inputs and the plant/damper drivers; the existing single-zone thermostat becomes one zone's demand source.

Parameters:
- NUM_ZONES, 4, number of zones (2..8).
- TEMP_W, 5, temperature width in degrees C, unsigned.
- LOW_TH, 18, heat request when temp <= LOW_TH.
- HIGH_TH, 22, cool request when temp >= HIGH_TH.
- TARGET, 20, zone is satisfied at this value (heat: temp >= TARGET; cool: temp <= TARGET).
- MIN_ON, 8, minimum SERVE cycles per grant.
- MAX_ON, 32, SERVE cycles after which a grant is pre-empted if another zone requests.
- DEAD_CYCLES, 4, all-off cycles after every grant.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scheduler enable.
- temp_flat  in  NUM_ZONES*TEMP_W  zone temperatures; zone i occupies bits [i*TEMP_W +: TEMP_W]; synchronous to clk.
- zone_sel  out  NUM_ZONES  one-hot damper select, 0 when idle.
- heating  out  1  plant heat command.
- cooling  out  1  plant cool command.
- active_zone  out  clog2(NUM_ZONES)  index of the granted zone.
- busy  out  1  high in SERVE and DEAD.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - heating, cooling, busy, zone_sel, active_zone, rr_ptr and counter all 0.
- All outputs are registered.
- Demand decode (combinational, per zone):
  - heat_req[i] = temp_i <= LOW_TH.
  - cool_req[i] = temp_i >= HIGH_TH.
  - LOW_TH < HIGH_TH, so a zone never requests both.
  - req[i] = heat_req[i] | cool_req[i].
- FSM states: IDLE, SERVE, DEAD.
- IDLE:
  - If enable=1 and any req is set, pick the first requesting zone at or above rr_ptr, wrapping modulo NUM_ZONES.
  - Next cycle: SERVE, zone_sel=onehot(pick), active_zone=pick, heating=heat_req[pick], cooling=cool_req[pick], counter=0.
  - Grant latency is 1 cycle from the request being sampled.
- SERVE:
  - Mode is latched at grant and never changes within a grant.
  - Counter increments every cycle and saturates at MAX_ON.
  - Exit to DEAD at the first clock edge where any of these holds:
    - (a) enable=0: immediate, regardless of MIN_ON.
    - (b) zone satisfied and counter >= MIN_ON-1.
    - (c) counter >= MAX_ON-1 and req from any other zone.
  - An unsatisfied zone with no competing request stays in SERVE indefinitely.
- On exit to DEAD:
  - heating=0, cooling=0, zone_sel=0.
  - rr_ptr = (active_zone+1) mod NUM_ZONES.
  - counter=0.
  - active_zone holds its last value.
- DEAD:
  - All plant outputs stay 0 for exactly DEAD_CYCLES cycles, then IDLE.
  - The earliest next grant is DEAD_CYCLES+1 cycles after the exit edge.
- Invariants:
  - heating & cooling is never 1.
  - zone_sel is one-hot or zero, and zero whenever heating=cooling=0.
  - Any heat->cool or cool->heat change passes through at least DEAD_CYCLES all-off cycles.
- Boundaries:
  - temp=LOW_TH requests heat; LOW_TH+1 does not.
  - temp=HIGH_TH requests cool; HIGH_TH-1 does not.
  - A zone whose request drops mid-SERVE is still served until (a)/(b)/(c).
  - rr_ptr wraps from NUM_ZONES-1 to 0.
  - enable=0 in IDLE or DEAD: no grant; DEAD still completes.
  - Reset mid-SERVE: outputs go 0 asynchronously.

Decomposition:
- hvac_pkg holds:
  - the state enum (IDLE, SERVE, DEAD);
  - the mode encoding (OFF, HEAT, COOL);
  - default threshold constants (18/20/22).
- One sub-module, zone_rr_picker:
  - combinational round-robin pick from a req vector and rr_ptr;
  - outputs a valid flag and the picked index.

Test Plan (defaults, all zones 20 unless stated):
- Reset/idle: hold rst_n=0 5 cycles, release, all zones 20 for 20 cycles -> all outputs 0, busy=0.
- Single heat: zone 2=16 -> next cycle zone_sel=0100, heating=1, active_zone=2; set zone 2=20 at SERVE cycle 2 -> heating stays 1 until SERVE cycle 7, then 0 for exactly 4 cycles, busy falls after them.
- Round-robin: zones 0 and 3=25 -> zone 0 cooled first; zone 0=20 after 10 cycles -> 4 dead cycles, then zone_sel=1000, cooling=1.
- Pre-emption/mode change: zone 1=15 held, zone 2=24 -> zone 1 heats exactly 32 cycles, 4 all-off cycles, then zone 2 cools; heating&cooling never both 1.
- Enable/reset mid-serve: drop enable at SERVE cycle 3 -> next cycle outputs 0 despite MIN_ON, then DEAD, then IDLE with no grant; separately, pulse rst_n low mid-SERVE -> outputs 0 without waiting for a clock edge.
- Thresholds: zone 0 = 18/19/21/22 in turn -> heat grant / none / none / cool grant.
